// File: rtl/region_raster_scanner_pkg.sv
// region_raster_scanner_pkg: frame geometry defaults and the scanner state encoding that the
// top-level state machine and the colour generators share.
package region_raster_scanner_pkg;
   localparam int SCREEN_H_RES  = 160;
   localparam int SCREEN_V_RES  = 120;
   localparam int PIANO_TOP_ROW = 92;
   typedef enum logic [1:0] {SCAN_IDLE, SCAN_LOAD, SCAN_SCAN, SCAN_DONE} scan_state_e;
endpackage

// File: rtl/region_raster_scanner.sv
// region_raster_scanner: walks a full frame or a clamped row band, emitting X, Y and linear
// address per pixel with a start/done handshake, downstream stall and abort.
module region_raster_scanner
   import region_raster_scanner_pkg::*;
#(
   parameter int H_RES  = SCREEN_H_RES,
   parameter int V_RES  = SCREEN_V_RES,
   parameter int X_W    = 8,
   parameter int Y_W    = 8,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [Y_W-1:0]    rowStart,
   input  logic [Y_W-1:0]    rowEnd,
   input  logic              stall,
   input  logic              abort,
   output logic [X_W-1:0]    outX,
   output logic [Y_W-1:0]    outY,
   output logic [ADDR_W-1:0] outAddr,
   output logic              outValid,
   output logic              busy,
   output logic              done
);
   localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

   scan_state_e       state_q, state_d;
   logic [Y_W-1:0]    row_start_q, row_start_d, row_end_q, row_end_d, end_clamped;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              valid_q, valid_d, accept, last, active;

   always_comb begin
      end_clamped = rowEnd > Y_LAST ? Y_LAST : rowEnd;
      accept      = valid_q & ~stall;
      last        = accept && x_q == X_LAST && y_q == row_end_q;
      active      = state_q == SCAN_LOAD || state_q == SCAN_SCAN;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN_IDLE;
         row_start_q <= '0;
         row_end_q   <= '0;
         x_q         <= '0;
         y_q         <= '0;
         addr_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_start_q <= row_start_d;
         row_end_q   <= row_end_d;
         x_q         <= x_d;
         y_q         <= y_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
      end
   end

   // An empty band skips LOAD/SCAN entirely so done still pulses exactly once.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN_IDLE: if (start) state_d = rowStart > end_clamped ? SCAN_DONE : SCAN_LOAD;
         SCAN_LOAD: state_d = abort ? SCAN_IDLE : SCAN_SCAN;
         SCAN_SCAN: state_d = abort ? SCAN_IDLE : last ? SCAN_DONE : SCAN_SCAN;
         default:   state_d = SCAN_IDLE;
      endcase
   end

   // The row-base multiply happens once in LOAD; SCAN only ever increments the address.
   always_comb begin
      row_start_d = row_start_q;
      row_end_d   = row_end_q;
      x_d         = x_q;
      y_d         = y_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      if (state_q == SCAN_IDLE && start) begin
         row_start_d = rowStart;
         row_end_d   = end_clamped;
      end
      if ((active && abort) || last) begin
         x_d     = '0;
         y_d     = '0;
         addr_d  = '0;
         valid_d = 1'b0;
      end else if (state_q == SCAN_LOAD) begin
         x_d     = '0;
         y_d     = row_start_q;
         addr_d  = ADDR_W'(row_start_q) * ADDR_W'(H_RES);
         valid_d = 1'b1;
      end else if (accept) begin
         x_d    = x_q == X_LAST ? '0 : x_q + X_W'(1);
         y_d    = x_q == X_LAST ? y_q + Y_W'(1) : y_q;
         addr_d = addr_q + ADDR_W'(1);
      end
   end

   always_comb begin
      busy     = active;
      done     = state_q == SCAN_DONE;
      outX     = x_q;
      outY     = y_q;
      outAddr  = addr_q;
      outValid = valid_q;
   end
endmodule

// File: tb/tb_region_raster_scanner.sv
// tb_region_raster_scanner: table of band scans plus random bands, abort and reset sequences,
// checked against a pixel-index model of the expected raster order.
module tb_region_raster_scanner;
   import region_raster_scanner_pkg::*;
   localparam int H = SCREEN_H_RES;
   localparam int V = SCREEN_V_RES;

   logic        clk = 0, reset = 0, start = 0, stall = 0, abort = 0;
   logic [7:0]  rowStart = 0, rowEnd = 0, outX, outY;
   logic [14:0] outAddr;
   logic        outValid, busy, done;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   region_raster_scanner dut (
      .clk(clk), .reset(reset), .start(start), .rowStart(rowStart), .rowEnd(rowEnd),
      .stall(stall), .abort(abort), .outX(outX), .outY(outY), .outAddr(outAddr),
      .outValid(outValid), .busy(busy), .done(done)
   );

   typedef struct {
      int rs;
      int re;
      int mode;
      int cnt;
      int first_a;
      int last_a;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pixel k of a band is column k%H of row rs+k/H at address rs*H+k.
   // mode 0: no stall, 1: random stall, 2: stall 3 cycles while pixel 5 is presented.
   task automatic run_scan(input int rs, input int re, input int mode, output int cnt,
                           output int first_a, output int last_a, output int dones,
                           output int bad, output int lat, output string why);
      int k = 0, hold = 0, cyc = 0, rec, limit;
      rec   = re > V - 1 ? V - 1 : re;
      limit = (rs > rec ? 0 : (rec - rs + 1) * H) * 2 + 50;
      cnt = 0; first_a = -1; last_a = -1; dones = 0; bad = 0; lat = -1; why = "";
      rowStart = 8'(rs); rowEnd = 8'(re); start = 1; stall = 0;
      while (cyc < limit) begin
         @(negedge clk);
         cyc++;
         start = 0;
         abort = 0;
         if (busy && done) begin bad++; why = "busy and done together"; end
         if (done) begin
            dones++;
            if (lat < 0) lat = cyc;
            if (outX !== 0 || outY !== 0 || outAddr !== 0 || outValid !== 0) begin
               bad++; why = "nonzero outputs in done";
            end
         end
         if (outValid) begin
            if (lat < 0) lat = cyc;
            if (outX !== 8'(k % H) || outY !== 8'(rs + k / H) || outAddr !== 15'(rs * H + k) || !busy) begin
               if (bad == 0)
                  why = $sformatf("pixel %0d got (%0d,%0d,%0d)", k, outX, outY, outAddr);
               bad++;
            end
         end
         if (dones > 0 && !done) break;
         stall = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2 && k == 5 && hold < 3);
         if (mode == 2 && stall) hold++;
         if (outValid && !stall) begin
            cnt++;
            if (first_a < 0) first_a = int'(outAddr);
            last_a = int'(outAddr);
            k++;
         end
      end
      stall = 0;
   endtask

   task automatic wait_pix(input int x, input int y, output int ok);
      ok = 0;
      for (int c = 0; c < 20000 && ok == 0; c++) begin
         @(negedge clk);
         ok = int'(outValid && outX == 8'(x) && outY == 8'(y));
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " outX"}, outX, 0);
      chk({tag, " outY"}, outY, 0);
      chk({tag, " outAddr"}, outAddr, 0);
      chk({tag, " outValid"}, outValid, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
   endtask

   initial begin
      vec_t  v;
      int    cnt, fa, la, dn, bad, lat, ok;
      string why;
      vecs[0] = '{0, 119, 2, 19200, 0, 19199};
      vecs[1] = '{PIANO_TOP_ROW, 119, 0, 4480, 14720, 19199};
      vecs[2] = '{50, 40, 0, 0, -1, -1};
      vecs[3] = '{0, 200, 0, 19200, 0, 19199};
      vecs[4] = '{110, 250, 1, 1600, 17600, 19199};
      vecs[5] = '{5, 5, 1, 160, 800, 959};
      vecs[6] = '{119, 119, 0, 160, 19040, 19199};

      #2 reset = 1;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      reset = 0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         run_scan(v.rs, v.re, v.mode, cnt, fa, la, dn, bad, lat, why);
         chk($sformatf("vec%0d count", i), cnt, v.cnt);
         chk($sformatf("vec%0d first_addr", i), fa, v.first_a);
         chk($sformatf("vec%0d last_addr", i), la, v.last_a);
         chk($sformatf("vec%0d done_pulses", i), dn, 1);
         chk($sformatf("vec%0d latency", i), lat, v.cnt > 0 ? 2 : 1);
         chk($sformatf("vec%0d pixels %s", i, why), bad, 0);
      end

      for (int i = 0; i < 6; i++) begin
         int rs, re, rec, ec;
         rs  = $urandom_range(1, 125);
         re  = $urandom_range(0, 3) == 0 ? rs - 1 : rs + $urandom_range(0, 2);
         rec = re > V - 1 ? V - 1 : re;
         ec  = rs > rec ? 0 : (rec - rs + 1) * H;
         run_scan(rs, re, 1, cnt, fa, la, dn, bad, lat, why);
         chk($sformatf("rand%0d band %0d..%0d count", i, rs, re), cnt, ec);
         chk($sformatf("rand%0d first_addr", i), fa, ec > 0 ? rs * H : -1);
         chk($sformatf("rand%0d done_pulses", i), dn, 1);
         chk($sformatf("rand%0d pixels %s", i, why), bad, 0);
      end

      // start held high through the scan must be ignored; abort then beats stall
      rowStart = 2; rowEnd = 10; start = 1;
      wait_pix(10, 3, ok);
      chk("abort reach (10,3)", ok, 1);
      chk("abort addr before", outAddr, 490);
      abort = 1; stall = 1; start = 0;
      @(negedge clk);
      abort = 0; stall = 0;
      chk_idle("abort");
      dn = 0;
      repeat (5) begin
         @(negedge clk);
         dn += int'(done);
      end
      chk("abort no done", dn, 0);

      abort = 1;
      run_scan(119, 119, 0, cnt, fa, la, dn, bad, lat, why);
      chk("start+abort idle count", cnt, 160);
      chk("start+abort idle done", dn, 1);

      rowStart = 58; rowEnd = 119; start = 1;
      @(negedge clk);
      start = 0;
      wait_pix(80, 60, ok);
      chk("reset reach (80,60)", ok, 1);
      chk("reset addr before", outAddr, 9680);
      #2 reset = 1;
      #1 chk_idle("midscan reset");
      @(negedge clk);
      reset = 0;
      run_scan(0, 1, 0, cnt, fa, la, dn, bad, lat, why);
      chk("restart first_addr", fa, 0);
      chk("restart count", cnt, 320);
      chk("restart done", dn, 1);
      chk($sformatf("restart pixels %s", why), bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
